// File: rtl/instr_fetch_queue_pkg.sv
// instr_fetch_queue_pkg: shared instruction-word layout, fetch FSM encoding and queue entry sizing
package instr_fetch_queue_pkg;
  localparam int opcode_lsb = 0;
  localparam int default_opcode_width = 5;
  localparam int default_nop_opcode = 0;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;
  // Queue entry is {instr, block, last}, MSB to LSB
  function automatic int entry_width(input int iw, input int bw);
    return iw + bw + 1;
  endfunction
endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: control, instruction-memory and decoder-side signals of the fetch queue
interface instr_fetch_queue_if #(
  parameter int instr_width = 32,
  parameter int n_blocks = 256
);
  localparam int bw = $clog2(n_blocks);
  logic enable;
  logic sample_tick;
  logic [bw-1:0] n_blocks_running;
  logic [bw-1:0] last_block;
  logic instr_read_en;
  logic [bw-1:0] instr_read_addr;
  logic [instr_width-1:0] instr_read_val;
  logic out_valid;
  logic out_ready;
  logic [instr_width-1:0] instr_out;
  logic [bw-1:0] block_out;
  logic last_out;
  logic frame_done;
  logic overrun;
  modport master (
    input enable, sample_tick, n_blocks_running, last_block, instr_read_val, out_ready,
    output instr_read_en, instr_read_addr, out_valid, instr_out, block_out, last_out, frame_done, overrun
  );
  modport slave (
    output enable, sample_tick, n_blocks_running, last_block, instr_read_val, out_ready,
    input instr_read_en, instr_read_addr, out_valid, instr_out, block_out, last_out, frame_done, overrun
  );
endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// instr_fetch_queue_fetch_fifo: synchronous first-word-fall-through FIFO with occupancy count
module instr_fetch_queue_fetch_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push_i,
  input  logic [width-1:0] din_i,
  input  logic pop_i,
  output logic [width-1:0] dout_o,
  output logic [$clog2(depth):0] count_o
);
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  logic [width-1:0] mem_q [depth];
  logic [aw-1:0] wr_q, rd_q;
  logic [cw-1:0] count_q;
  logic do_pop, do_push;
  assign do_pop = pop_i && count_q != '0;
  assign do_push = push_i && (count_q != cw'(depth) || do_pop);
  assign dout_o = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + aw'(1);
      end
      if (do_pop) rd_q <= rd_q + aw'(1);
      count_q <= count_q + cw'(do_push) - cw'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: frame-based instruction fetcher that drops NOPs and queues words for the decoder
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int instr_width = 32,
  parameter int n_blocks = 256,
  parameter int fifo_depth = 4,
  parameter int mem_latency = 1,
  parameter int opcode_width = default_opcode_width,
  parameter int nop_opcode = default_nop_opcode
) (
  input logic clk,
  input logic reset_n,
  instr_fetch_queue_if.master bus
);
  localparam int bw = $clog2(n_blocks);
  localparam int cw = $clog2(fifo_depth) + 1;
  localparam int ew = entry_width(instr_width, bw);
  fetch_state_e state_q, state_d;
  logic [bw-1:0] last_q, last_d, addr_q, addr_d, rd_addr_q, rd_addr_d;
  logic [bw-1:0] cur, lim, ret_a, h_block;
  logic rd_en_q, frame_done_q, overrun_q;
  logic issue, start, drain_done, ret_v, push, pop, valid, h_last;
  logic [mem_latency-1:0] fv_q;
  logic [bw-1:0] fa_q [mem_latency];
  logic [cw-1:0] count;
  logic [ew-1:0] din, dout;
  logic [instr_width-1:0] h_instr;
  int in_flight;
  always_comb begin
    in_flight = int'(rd_en_q);
    for (int i = 0; i < mem_latency; i++) in_flight += int'(fv_q[i]);
  end
  assign ret_v = fv_q[mem_latency-1];
  assign ret_a = fa_q[mem_latency-1];
  assign push = ret_v && bus.instr_read_val[opcode_lsb +: opcode_width] != opcode_width'(nop_opcode);
  assign din = {bus.instr_read_val, ret_a, ret_a == last_q};
  assign valid = count != '0;
  assign pop = valid && bus.out_ready && bus.enable;
  assign drain_done = state_q == DRAIN && count == '0 && in_flight == 0;
  // A tick on the cycle the previous frame drains counts as a fresh start, not an overrun
  assign start = bus.sample_tick && bus.n_blocks_running != '0 && (state_q == IDLE || drain_done);
  assign cur = start ? '0 : addr_q;
  assign lim = start ? bus.last_block : last_q;
  // Credits cover both queued entries and reads still in the memory pipe, so a return never finds the queue full
  assign issue = (start || state_q == FETCH) && bus.enable && int'(count) + in_flight < fifo_depth;
  always_comb begin
    state_d = issue && cur == lim ? DRAIN : start ? FETCH : drain_done ? IDLE : state_q;
    last_d = lim;
    addr_d = issue ? cur + bw'(1) : cur;
    rd_addr_d = issue ? cur : rd_addr_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= '0;
      addr_q <= '0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      fv_q <= '0;
      frame_done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      addr_q <= addr_d;
      rd_en_q <= issue;
      rd_addr_q <= rd_addr_d;
      frame_done_q <= drain_done;
      overrun_q <= bus.sample_tick && (state_q == FETCH || (state_q == DRAIN && !drain_done));
      fv_q[0] <= rd_en_q;
      for (int i = 1; i < mem_latency; i++) fv_q[i] <= fv_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    fa_q[0] <= rd_addr_q;
    for (int i = 1; i < mem_latency; i++) fa_q[i] <= fa_q[i-1];
  end
  instr_fetch_queue_fetch_fifo #(.width(ew), .depth(fifo_depth)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push_i(push),
    .din_i(din),
    .pop_i(pop),
    .dout_o(dout),
    .count_o(count)
  );
  assign {h_instr, h_block, h_last} = dout;
  assign bus.out_valid = valid;
  assign bus.instr_out = valid ? h_instr : '0;
  assign bus.block_out = valid ? h_block : '0;
  assign bus.last_out = valid && h_last;
  assign bus.instr_read_en = rd_en_q;
  assign bus.instr_read_addr = rd_addr_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench for latency-1 and latency-3 fetch queues
module tb_instr_fetch_queue;
  localparam int iw = 32;
  localparam int nb = 16;
  localparam int bw = 4;
  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t = 0;
  logic [iw-1:0] mem [nb];
  logic [iw-1:0] p1 [2];
  int s0c[$], s0a[$], o0c[$], s1c[$], s1a[$], o1c[$], exp_q[$];
  logic [iw+bw:0] o0[$], o1[$];
  int fd0 = 0, ov0 = 0, fd1 = 0, ov1 = 0, v1 = 0;

  instr_fetch_queue_if #(.instr_width(iw), .n_blocks(nb)) b0 ();
  instr_fetch_queue_if #(.instr_width(iw), .n_blocks(nb)) b1 ();
  instr_fetch_queue #(.instr_width(iw), .n_blocks(nb), .fifo_depth(4), .mem_latency(1)) u0 (
    .clk(clk), .reset_n(rst0_n), .bus(b0.master));
  instr_fetch_queue #(.instr_width(iw), .n_blocks(nb), .fifo_depth(4), .mem_latency(3)) u1 (
    .clk(clk), .reset_n(rst1_n), .bus(b1.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    b0.instr_read_val <= b0.instr_read_en ? mem[b0.instr_read_addr] : '0;
    p1[0] <= b1.instr_read_en ? mem[b1.instr_read_addr] : '0;
    p1[1] <= p1[0];
    b1.instr_read_val <= p1[1];
  end

  always @(negedge clk) begin
    if (b0.instr_read_en) begin s0c.push_back(cyc); s0a.push_back(int'(b0.instr_read_addr)); end
    if (b0.out_valid && b0.out_ready && b0.enable) begin
      o0c.push_back(cyc); o0.push_back({b0.last_out, b0.block_out, b0.instr_out});
    end
    fd0 += int'(b0.frame_done);
    ov0 += int'(b0.overrun);
    if (b1.instr_read_en) begin s1c.push_back(cyc); s1a.push_back(int'(b1.instr_read_addr)); end
    if (b1.out_valid && b1.out_ready && b1.enable) begin
      o1c.push_back(cyc); o1.push_back({b1.last_out, b1.block_out, b1.instr_out});
    end
    fd1 += int'(b1.frame_done);
    ov1 += int'(b1.overrun);
    v1 += int'(b1.out_valid);
  end

  function automatic logic [iw-1:0] w(input int i);
    return 32'hA000_0000 | (32'(i) << 8) | 32'd3;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin errors++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end
  endtask

  task automatic clr();
    s0c.delete(); s0a.delete(); o0c.delete(); o0.delete();
    s1c.delete(); s1a.delete(); o1c.delete(); o1.delete();
    fd0 = 0; ov0 = 0; fd1 = 0; ov1 = 0; v1 = 0;
  endtask

  task automatic chk_out(input string tag, input int lb, input bit d);
    int n;
    n = d ? o1.size() : o0.size();
    chki($sformatf("%s_count", tag), n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk($sformatf("%s_entry%0d", tag, i), 64'(d ? o1[i] : o0[i]),
          64'({exp_q[i] == lb, bw'(exp_q[i]), w(exp_q[i])}));
  endtask

  task automatic chk_addr(input string tag, input int n, input int period);
    chki($sformatf("%s_strobes", tag), s0a.size(), n);
    for (int i = 0; i < n && i < s0a.size(); i++)
      chki($sformatf("%s_addr%0d", tag, i), s0a[i], i % period);
  endtask

  initial begin
    for (int i = 0; i < nb; i++) mem[i] = w(i);
    b0.enable = 1'b1; b0.sample_tick = 1'b0; b0.n_blocks_running = 4'd1; b0.last_block = 4'd0; b0.out_ready = 1'b1;
    b1.enable = 1'b1; b1.sample_tick = 1'b0; b1.n_blocks_running = 4'd1; b1.last_block = 4'd0; b1.out_ready = 1'b1;
    step(3);
    chk("reset0", 64'({b0.instr_read_en, b0.instr_read_addr, b0.out_valid, b0.instr_out, b0.block_out,
                       b0.last_out, b0.frame_done, b0.overrun}), 64'd0);
    chk("reset1", 64'({b1.instr_read_en, b1.instr_read_addr, b1.out_valid, b1.instr_out, b1.block_out,
                       b1.last_out, b1.frame_done, b1.overrun}), 64'd0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    step(2);
    // basic 4-block frame
    clr(); b0.last_block = 4'd3; b0.sample_tick = 1'b1; t = cyc;
    step(1); b0.sample_tick = 1'b0; step(14);
    chk_addr("t1", 4, 16);
    for (int i = 0; i < 4 && i < s0c.size(); i++) chki($sformatf("t1_strobe_cyc%0d", i), s0c[i], t + 1 + i);
    chki("t1_first_out_cyc", o0c.size() > 0 ? o0c[0] : -1, t + 3);
    exp_q = {0, 1, 2, 3}; chk_out("t1", 3, 1'b0);
    chki("t1_frame_done", fd0, 1);
    chki("t1_overrun", ov0, 0);
    // NOPs at blocks 1 and 2
    mem[1] = 32'hB000_0100; mem[2] = 32'hB000_0200;
    clr(); b0.sample_tick = 1'b1; step(1); b0.sample_tick = 1'b0; step(14);
    chk_addr("t2", 4, 16);
    exp_q = {0, 3}; chk_out("t2", 3, 1'b0);
    chki("t2_frame_done", fd0, 1);
    mem[1] = w(1); mem[2] = w(2);
    // backpressure: only fifo_depth reads outstanding
    clr(); b0.out_ready = 1'b0; b0.last_block = 4'd7; b0.sample_tick = 1'b1;
    step(1); b0.sample_tick = 1'b0; step(12);
    chki("t3_stalled_strobes", s0a.size(), 4);
    chki("t3_stalled_pops", o0.size(), 0);
    chk("t3_head", 64'({b0.out_valid, b0.block_out, b0.last_out, b0.instr_out}), 64'({1'b1, 4'd0, 1'b0, w(0)}));
    b0.out_ready = 1'b1; step(25);
    chk_addr("t3", 8, 16);
    exp_q = {0, 1, 2, 3, 4, 5, 6, 7}; chk_out("t3", 7, 1'b0);
    chki("t3_frame_done", fd0, 1);
    // second tick two cycles into a frame
    clr(); b0.last_block = 4'd3; b0.sample_tick = 1'b1;
    step(1); b0.sample_tick = 1'b0; step(1); b0.sample_tick = 1'b1; step(1); b0.sample_tick = 1'b0; step(14);
    chki("t4a_overrun", ov0, 1);
    chk_addr("t4a", 4, 16);
    exp_q = {0, 1, 2, 3}; chk_out("t4a", 3, 1'b0);
    chki("t4a_frame_done", fd0, 1);
    // tick on the drain-complete cycle starts a new frame
    clr(); b0.sample_tick = 1'b1; t = cyc;
    step(1); b0.sample_tick = 1'b0; step(6); b0.sample_tick = 1'b1; step(1); b0.sample_tick = 1'b0; step(14);
    chki("t4b_overrun", ov0, 0);
    chki("t4b_frame_done", fd0, 2);
    chk_addr("t4b", 8, 4);
    chki("t4b_restart_cyc", s0c.size() > 4 ? s0c[4] : -1, t + 8);
    exp_q = {0, 1, 2, 3, 0, 1, 2, 3}; chk_out("t4b", 3, 1'b0);
    // idle engine ignores the tick
    clr(); b0.n_blocks_running = 4'd0; b0.sample_tick = 1'b1; step(1); b0.sample_tick = 1'b0; step(5);
    chki("t5_strobes", s0a.size(), 0);
    chki("t5_overrun", ov0, 0);
    chki("t5_out_valid", int'(b0.out_valid), 0);
    b0.n_blocks_running = 4'd1;
    // enable low freezes issue and pop while returns still land
    clr(); b0.last_block = 4'd7; b0.sample_tick = 1'b1; t = cyc;
    step(1); b0.sample_tick = 1'b0; step(1); b0.enable = 1'b0; step(4);
    chki("t6_frozen_strobes", s0a.size(), 2);
    chki("t6_frozen_pops", o0.size(), 0);
    chk("t6_head_held", 64'({b0.out_valid, b0.block_out, b0.instr_out}), 64'({1'b1, 4'd0, w(0)}));
    step(1); b0.enable = 1'b1; step(25);
    chki("t6_resume_cyc", s0c.size() > 2 ? s0c[2] : -1, t + 8);
    chk_addr("t6", 8, 16);
    exp_q = {0, 1, 2, 3, 4, 5, 6, 7}; chk_out("t6", 7, 1'b0);
    chki("t6_frame_done", fd0, 1);
    // latency 3: reset with two reads in flight
    clr(); b1.last_block = 4'd7; b1.sample_tick = 1'b1;
    step(1); b1.sample_tick = 1'b0; step(1); rst1_n = 1'b0; step(1);
    chk("t7_reset_outputs", 64'({b1.instr_read_en, b1.instr_read_addr, b1.out_valid, b1.instr_out, b1.block_out,
                                 b1.last_out, b1.frame_done, b1.overrun}), 64'd0);
    chki("t7_pre_reset_strobes", s1a.size(), 2);
    rst1_n = 1'b1; step(10);
    chki("t7_no_new_strobes", s1a.size(), 2);
    chki("t7_no_out_valid", v1, 0);
    chki("t7_no_frame_done", fd1, 0);
    clr(); b1.sample_tick = 1'b1; t = cyc; step(1); b1.sample_tick = 1'b0; step(30);
    chki("t7_first_strobe_cyc", s1c.size() > 0 ? s1c[0] : -1, t + 1);
    chki("t7_first_out_cyc", o1c.size() > 0 ? o1c[0] : -1, t + 5);
    exp_q = {0, 1, 2, 3, 4, 5, 6, 7}; chk_out("t7", 7, 1'b1);
    chki("t7_frame_done", fd1, 1);
    chki("t7_overrun", ov1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
